// File: rtl/aes_pkg.sv
// Shared AES constants and helpers: block geometry, round count, S-box, GF(2^8) doubling,
// round constants and the FSM state encoding used by the iterative cipher.
package aes_pkg;

    localparam int unsigned Nb = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        DONE  = 2'd2
    } aesState_t;

    // Forward S-box, entry 0 in the most significant byte.
    localparam logic [2047:0] SboxTable = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic int unsigned nr_of(input int unsigned nk);
        return nk + 6;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SboxTable[{~b, 3'b111} -: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] subWord(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    // Rcon[j] = x^(j-1) in GF(2^8), j >= 1.
    function automatic logic [7:0] rcon(input int unsigned j);
        logic [7:0] r;
        r = 8'h01;
        for (int unsigned n = 1; n < j; n++) begin
            r = xtime(r);
        end
        return r;
    endfunction

endpackage

// File: rtl/aes_round.sv
// One combinational AES encryption round: SubBytes, ShiftRows, MixColumns (skipped when
// last_round is set) and AddRoundKey. Byte 0 of the state sits in bits [127:120].
module aes_round
    import aes_pkg::*;
(
    input  logic [127:0] stateIn,
    input  logic [127:0] roundKey,
    input  logic         last_round,
    output logic [127:0] roundOut_c
);

    logic [7:0] sb [16];
    logic [7:0] sr [16];
    logic [7:0] mc [16];

    genvar k, r, c;

    for (k = 0; k < 16; k++) begin : gSub
        assign sb[k] = sbox(stateIn[127-8*k -: 8]);
    end

    // State is column-major: byte index = row + 4*column.
    for (c = 0; c < 4; c++) begin : gShiftCol
        for (r = 0; r < 4; r++) begin : gShiftRow
            assign sr[r+4*c] = sb[r + 4*((c+r)%4)];
        end
    end

    for (c = 0; c < 4; c++) begin : gMix
        assign mc[4*c]   = xtime(sr[4*c]) ^ xtime(sr[4*c+1]) ^ sr[4*c+1] ^ sr[4*c+2] ^ sr[4*c+3];
        assign mc[4*c+1] = sr[4*c] ^ xtime(sr[4*c+1]) ^ xtime(sr[4*c+2]) ^ sr[4*c+2] ^ sr[4*c+3];
        assign mc[4*c+2] = sr[4*c] ^ sr[4*c+1] ^ xtime(sr[4*c+2]) ^ xtime(sr[4*c+3]) ^ sr[4*c+3];
        assign mc[4*c+3] = xtime(sr[4*c]) ^ sr[4*c] ^ sr[4*c+1] ^ sr[4*c+2] ^ xtime(sr[4*c+3]);
    end

    for (k = 0; k < 16; k++) begin : gAddKey
        assign roundOut_c[127-8*k -: 8] = (last_round ? sr[k] : mc[k]) ^ roundKey[127-8*k -: 8];
    end

endmodule

// File: rtl/aes_cipher_iter.sv
// Iterative AES-128/192/256 encryptor, one round per clock, valid/ready on both sides.
// AES_KEY_REG_EN: capture key_in at accept so the key may change during the rounds.
module aes_cipher_iter
    import aes_pkg::*;
#(
    parameter int unsigned Nk = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [127:0]      data_in,
    input  logic [Nk*32-1:0]  key_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [127:0]      data_out,
    output logic              busy
);

    localparam int unsigned Nr       = nr_of(Nk);
    localparam int unsigned KeyW     = Nk * 32;
    localparam int unsigned NumWords = Nb * (Nr + 1);
    localparam int unsigned WIdxW    = $clog2(NumWords);

    if (Nk != 4 && Nk != 6 && Nk != 8) begin : gBadNk
        $error("aes_cipher_iter: Nk must be 4, 6 or 8");
    end

    aesState_t    fsmQ, fsmD;
    logic [3:0]   roundQ, roundD;
    logic [127:0] blockQ, blockD;
    logic [127:0] dataOutQ, dataOutD;
    logic         outValidQ, outValidD;
    logic         busyQ, busyD;

    logic              accept;
    logic              lastRound;
    logic [KeyW-1:0]   keySrc;
    logic [127:0]      firstKey;
    logic [127:0]      curKey;
    logic [127:0]      roundOut;
    logic [31:0]       w [NumWords];

    assign in_ready  = (fsmQ == IDLE) || ((fsmQ == DONE) && out_ready);
    assign accept    = in_valid && in_ready;
    assign lastRound = (roundQ == 4'(Nr));
    // Round key 0 is the leading key words, so the initial whitening never needs the register.
    assign firstKey  = key_in[KeyW-1 -: 128];

`ifdef AES_KEY_REG_EN
    logic [KeyW-1:0] keyQ;

    always_ff @(posedge clk) begin
        if (rst) begin
            keyQ <= '0;
        end else if (accept) begin
            keyQ <= key_in;
        end
    end

    assign keySrc = keyQ;
`else
    assign keySrc = key_in;
`endif

    // Key expansion: all Nb*(Nr+1) schedule words from the selected key source.
    always_comb begin
        w = '{default: '0};
        for (int unsigned i = 0; i < NumWords; i++) begin
            if (i < Nk) begin
                w[WIdxW'(i)] = keySrc[KeyW-1-32*i -: 32];
            end else if (i % Nk == 0) begin
                w[WIdxW'(i)] = w[WIdxW'(i-Nk)]
                             ^ subWord({w[WIdxW'(i-1)][23:0], w[WIdxW'(i-1)][31:24]})
                             ^ {rcon(i / Nk), 24'h000000};
            end else if (Nk > 6 && i % Nk == 4) begin
                w[WIdxW'(i)] = w[WIdxW'(i-Nk)] ^ subWord(w[WIdxW'(i-1)]);
            end else begin
                w[WIdxW'(i)] = w[WIdxW'(i-Nk)] ^ w[WIdxW'(i-1)];
            end
        end
    end

    // Round key mux indexed by the round counter.
    always_comb begin
        curKey = '0;
        for (int unsigned r = 0; r <= Nr; r++) begin
            if (roundQ == 4'(r)) begin
                curKey = {w[WIdxW'(4*r)], w[WIdxW'(4*r+1)], w[WIdxW'(4*r+2)], w[WIdxW'(4*r+3)]};
            end
        end
    end

    aes_round u_round (
        .stateIn    (blockQ),
        .roundKey   (curKey),
        .last_round (lastRound),
        .roundOut_c (roundOut)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            fsmQ      <= IDLE;
            roundQ    <= '0;
            blockQ    <= '0;
            dataOutQ  <= '0;
            outValidQ <= 1'b0;
            busyQ     <= 1'b0;
        end else begin
            fsmQ      <= fsmD;
            roundQ    <= roundD;
            blockQ    <= blockD;
            dataOutQ  <= dataOutD;
            outValidQ <= outValidD;
            busyQ     <= busyD;
        end
    end

    always_comb begin
        fsmD      = fsmQ;
        roundD    = roundQ;
        blockD    = blockQ;
        dataOutD  = dataOutQ;
        outValidD = outValidQ;
        busyD     = busyQ;
        case (fsmQ)
            IDLE: begin
            end
            ROUND: begin
                blockD = roundOut;
                roundD = roundQ + 4'd1;
                if (lastRound) begin
                    fsmD      = DONE;
                    dataOutD  = roundOut;
                    outValidD = 1'b1;
                    busyD     = 1'b0;
                end
            end
            DONE: begin
                if (out_ready) begin
                    fsmD      = IDLE;
                    outValidD = 1'b0;
                end
            end
            default: fsmD = IDLE;
        endcase
        // A new block may be taken from IDLE or from DONE while the result is consumed.
        if (accept) begin
            blockD = data_in ^ firstKey;
            roundD = 4'd1;
            fsmD   = ROUND;
            busyD  = 1'b1;
        end
    end

    assign out_valid = outValidQ;
    assign data_out  = dataOutQ;
    assign busy      = busyQ;

endmodule

// File: tb/tb_aes_cipher_iter.sv
// Directed bench for aes_cipher_iter: FIPS-197 / SP800-38A vectors on Nk=4/6/8 instances,
// backpressure, back-to-back issue, mid-round reset and ignored in_valid during rounds.
module tb_aes_cipher_iter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic         out_ready;
    logic [127:0] data_in;
    logic         valid4, valid6, valid8;
    logic [127:0] key4;
    logic [191:0] key6;
    logic [255:0] key8;
    logic         rdy4, rdy6, rdy8;
    logic         ov4, ov6, ov8;
    logic [127:0] do4, do6, do8;
    logic         busy4, busy6, busy8;

    int checks = 0;
    int errors = 0;

    aes_cipher_iter #(.Nk(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(valid4), .in_ready(rdy4), .data_in(data_in),
        .key_in(key4), .out_valid(ov4), .out_ready(out_ready), .data_out(do4), .busy(busy4));

    aes_cipher_iter #(.Nk(6)) dut6 (
        .clk(clk), .rst(rst), .in_valid(valid6), .in_ready(rdy6), .data_in(data_in),
        .key_in(key6), .out_valid(ov6), .out_ready(out_ready), .data_out(do6), .busy(busy6));

    aes_cipher_iter #(.Nk(8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(valid8), .in_ready(rdy8), .data_in(data_in),
        .key_in(key8), .out_valid(ov8), .out_ready(out_ready), .data_out(do8), .busy(busy8));

    typedef struct {
        int           sel;
        logic [127:0] din;
        logic [255:0] key;
        logic [127:0] expct;
    } vec_t;

    vec_t vecs [6];

    localparam logic [127:0] PtB  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [255:0] KeyB = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
    localparam logic [127:0] CtB  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] PtC  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [255:0] KeyC = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] CtC4 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] PtE  = 128'h6bc1bee22e409f96e93d7e117393172a;
    localparam logic [127:0] CtE  = 128'h3ad77bb40d7a3660a89ecaf32466ef97;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic logic readyOf(input int sel);
        return (sel == 0) ? rdy4 : (sel == 1) ? rdy6 : rdy8;
    endfunction

    function automatic logic validOf(input int sel);
        return (sel == 0) ? ov4 : (sel == 1) ? ov6 : ov8;
    endfunction

    function automatic logic [127:0] dataOf(input int sel);
        return (sel == 0) ? do4 : (sel == 1) ? do6 : do8;
    endfunction

    function automatic logic busyOf(input int sel);
        return (sel == 0) ? busy4 : (sel == 1) ? busy6 : busy8;
    endfunction

    task automatic setKey(input logic [255:0] k);
        key4 = k[255:128];
        key6 = k[255:64];
        key8 = k;
    endtask

    // Issue one block to the selected instance, wait for its result, check value and latency.
    task automatic runBlock(input int sel, input logic [127:0] din, input logic [255:0] key,
                            input logic [127:0] expct, input string name, input bit scramble);
        int lat;
        @(negedge clk);
        data_in = din;
        setKey(key);
        valid4 = (sel == 0);
        valid6 = (sel == 1);
        valid8 = (sel == 2);
        #1 chk({name, "_in_ready"}, 128'(readyOf(sel)), 128'(1));
        @(posedge clk);
        @(negedge clk);
        valid4 = 1'b0;
        valid6 = 1'b0;
        valid8 = 1'b0;
        chk({name, "_busy"}, 128'(busyOf(sel)), 128'(1));
        lat = 0;
        while (!validOf(sel) && lat < 40) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (scramble) begin
`ifdef AES_KEY_REG_EN
                key4 = {$urandom, $urandom, $urandom, $urandom};
`endif
            end
        end
        chk({name, "_data"}, dataOf(sel), expct);
        chk({name, "_latency"}, 128'(lat), 128'(10 + 2 * sel));
    endtask

    initial begin
        int lat;
        int seen;

        vecs[0] = '{0, PtB, KeyB, CtB};
        vecs[1] = '{0, PtC, {KeyC[255:128], 128'h0}, CtC4};
        vecs[2] = '{1, PtC, {KeyC[255:64], 64'h0}, 128'hdda97ca4864cdfe06eaf70a0ec0d7191};
        vecs[3] = '{2, PtC, KeyC, 128'h8ea2b7ca516745bfeafc49904b496089};
        vecs[4] = '{0, PtE, KeyB, CtE};
        vecs[5] = '{0, 128'hae2d8a571e03ac9c9eb76fac45af8e51, KeyB,
                    128'hf5d3d58503b9699de785895a96fdbaaf};

        rst = 1'b1;
        out_ready = 1'b1;
        data_in = '0;
        valid4 = 1'b0;
        valid6 = 1'b0;
        valid8 = 1'b0;
        setKey('0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_out_valid", 128'(ov4), 128'(0));
        chk("reset_data_out", do4, 128'h0);
        chk("reset_busy", 128'(busy4), 128'(0));
        chk("reset_in_ready", 128'(rdy4), 128'(1));
        rst = 1'b0;

        for (int i = 0; i < 6; i++) begin
            runBlock(vecs[i].sel, vecs[i].din, vecs[i].key, vecs[i].expct,
                     $sformatf("vec%0d", i), 1'b0);
        end

        // Key may be scrambled after accept only when the key register is built.
        runBlock(0, PtB, KeyB, CtB, "keyscramble", 1'b1);

        // Backpressure, then accept a new block in the same cycle the result is taken.
        @(negedge clk);
        data_in = PtB;
        setKey(KeyB);
        valid4 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        valid4 = 1'b0;
        out_ready = 1'b0;
        lat = 0;
        while (!ov4 && lat < 40) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        chk("bp_latency", 128'(lat), 128'(10));
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("bp_hold_valid%0d", i), 128'(ov4), 128'(1));
            chk($sformatf("bp_hold_data%0d", i), do4, CtB);
            chk($sformatf("bp_hold_ready%0d", i), 128'(rdy4), 128'(0));
        end
        out_ready = 1'b1;
        valid4 = 1'b1;
        data_in = PtC;
        setKey({KeyC[255:128], 128'h0});
        #1 chk("bp_accept_ready", 128'(rdy4), 128'(1));
        @(posedge clk);
        @(negedge clk);
        valid4 = 1'b0;
        chk("bp_valid_drop", 128'(ov4), 128'(0));
        lat = 0;
        while (!ov4 && lat < 40) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        chk("bp_second_data", do4, CtC4);
        chk("bp_second_latency", 128'(lat), 128'(10));

        // Back-to-back without backpressure: results Nr+1 cycles apart.
        runBlock(0, PtB, KeyB, CtB, "b2b_first", 1'b0);
        data_in = PtE;
        setKey(KeyB);
        valid4 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        valid4 = 1'b0;
        lat = 1;
        while (!ov4 && lat < 40) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        chk("b2b_spacing", 128'(lat), 128'(11));
        chk("b2b_second_data", do4, CtE);

        // Reset while at round 5: partial result must never appear.
        @(negedge clk);
        data_in = PtC;
        setKey({KeyC[255:128], 128'h0});
        valid4 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        valid4 = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_out_valid", 128'(ov4), 128'(0));
        chk("midrst_data_out", do4, 128'h0);
        chk("midrst_in_ready", 128'(rdy4), 128'(1));
        chk("midrst_busy", 128'(busy4), 128'(0));
        seen = 0;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (ov4) seen++;
        end
        chk("midrst_no_result", 128'(seen), 128'(0));
        runBlock(0, PtB, KeyB, CtB, "after_rst", 1'b0);

        // in_valid pulsed mid-round must be ignored.
        @(negedge clk);
        data_in = PtB;
        setKey(KeyB);
        valid4 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        valid4 = 1'b0;
        lat = 0;
        while (!ov4 && lat < 40) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (lat == 3) begin
                data_in = PtE;
                valid4 = 1'b1;
                #1 chk("pulse_in_ready", 128'(rdy4), 128'(0));
            end else begin
                valid4 = 1'b0;
            end
        end
        chk("pulse_data", do4, CtB);
        chk("pulse_latency", 128'(lat), 128'(10));
        @(posedge clk);
        @(negedge clk);
        chk("pulse_idle_after", 128'(ov4), 128'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
